// File: rtl/mmio_mac_stage.sv
// rtl/mmio_mac_stage.sv - two-stage signed byte-lane dot-product MAC with saturating accumulator
module mmio_mac_stage #(
    parameter int LANES = 8,
    parameter int DW    = 8,
    parameter int ACCW  = 24,
    parameter int CNTW  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [LANES*DW-1:0]   a_in,
    input  logic [LANES*DW-1:0]   b_in,
    input  logic                  clr,
    output logic [ACCW-1:0]       acc,
    output logic                  acc_valid,
    output logic                  sat,
    output logic [CNTW-1:0]       count
);

    localparam int PW   = 2 * DW;
    localparam int SUMW = PW + $clog2(LANES);

    logic signed [PW-1:0]   a_ext [LANES];
    logic signed [PW-1:0]   b_ext [LANES];
    logic signed [PW-1:0]   prod  [LANES];
    logic signed [PW-1:0]   p     [LANES];
    logic                   v1;
    logic signed [SUMW-1:0] sum;
    logic signed [ACCW:0]   t;

    // Lanes are widened to the product width first so the multiply is full precision.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            a_ext[i] = PW'($signed(a_in[i*DW +: DW]));
            b_ext[i] = PW'($signed(b_in[i*DW +: DW]));
            prod[i]  = a_ext[i] * b_ext[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LANES; i++) begin
                p[i] <= '0;
            end
            v1 <= 1'b0;
        end else begin
            if (en) begin
                for (int i = 0; i < LANES; i++) begin
                    p[i] <= prod[i];
                end
            end
            v1 <= en;
        end
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < LANES; i++) begin
            sum = sum + SUMW'(p[i]);
        end
        t = (ACCW+1)'($signed(acc)) + (ACCW+1)'(sum);
    end

    // t is one bit wider than acc, so a disagreement of its top two bits means overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            acc_valid <= 1'b0;
            sat       <= 1'b0;
            count     <= '0;
        end else if (clr) begin
            acc       <= '0;
            acc_valid <= 1'b0;
            sat       <= 1'b0;
            count     <= '0;
        end else if (v1) begin
            if (t[ACCW] != t[ACCW-1]) begin
                sat <= 1'b1;
                if (t[ACCW]) begin
                    acc <= {1'b1, {(ACCW-1){1'b0}}};
                end else begin
                    acc <= {1'b0, {(ACCW-1){1'b1}}};
                end
            end else begin
                acc <= t[ACCW-1:0];
            end
            if (count != {CNTW{1'b1}}) begin
                count <= count + CNTW'(1);
            end
            acc_valid <= 1'b1;
        end else begin
            acc_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mmio_mac_stage.sv
// tb/tb_mmio_mac_stage.sv - scoreboard testbench for mmio_mac_stage
module tb_mmio_mac_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [63:0] a_in;
    logic [63:0] b_in;
    logic        clr;
    logic [23:0] acc;
    logic        acc_valid;
    logic        sat;
    logic [15:0] count;

    typedef struct packed {
        logic [23:0] acc;
        logic [15:0] count;
        logic        sat;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   pulses   = 0;

    mmio_mac_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .a_in      (a_in),
        .b_in      (b_in),
        .clr       (clr),
        .acc       (acc),
        .acc_valid (acc_valid),
        .sat       (sat),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic push(input logic [23:0] a, input logic [15:0] c, input logic s);
        exp_t e;
        e.acc = a;
        e.count = c;
        e.sat = s;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_state(input string name);
        check({name, "_acc"}, 32'(acc), 32'h0);
        check({name, "_count"}, 32'(count), 32'h0);
        check({name, "_sat"}, 32'(sat), 32'h0);
        check({name, "_valid"}, 32'(acc_valid), 32'h0);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
        idle_state("clr");
    endtask

    // Monitor: every acc_valid pulse is matched against the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && acc_valid === 1'b1) begin
            exp_t e;
            pulses++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid actual acc=0x%0h count=%0d required=no pulse", acc, count);
            end else begin
                e = exp_q.pop_front();
                check("sb_acc", 32'(acc), 32'(e.acc));
                check("sb_count", 32'(count), 32'(e.count));
                check("sb_sat", 32'(sat), 32'(e.sat));
            end
        end
    end

    initial begin
        int p0;
        rst_n = 1'b0;
        en    = 1'b0;
        clr   = 1'b0;
        a_in  = '0;
        b_in  = '0;

        // 1. reset with inputs toggling
        for (int i = 0; i < 5; i++) begin
            en   = 1'($urandom);
            clr  = 1'($urandom);
            a_in = {$urandom, $urandom};
            b_in = {$urandom, $urandom};
            step();
        end
        idle_state("reset");
        en  = 1'b0;
        clr = 1'b0;
        rst_n = 1'b1;
        step();
        step();
        step();
        idle_state("post_reset");

        // 2. basic dot product, b_in changes after the strobe must not matter
        p0 = pulses;
        a_in = 64'h0102030405060708;
        b_in = 64'h0101010101010101;
        en = 1'b1;
        push(24'd36, 16'd1, 1'b0);
        step();
        en = 1'b0;
        b_in = 64'h7F7F7F7F7F7F7F7F;
        step();
        check("basic_acc", 32'(acc), 32'h24);
        step();
        step();
        check("basic_pulses", 32'(pulses - p0), 32'd1);
        check("basic_valid_low", 32'(acc_valid), 32'h0);
        do_clr();

        // 3. signed accumulate
        p0 = pulses;
        a_in = 64'hFFFF_FFFF_FFFF_FFFF;
        b_in = 64'h0202020202020202;
        en = 1'b1;
        push(24'hFFFFF0, 16'd1, 1'b0);
        push(24'hFFFFE0, 16'd2, 1'b0);
        step();
        step();
        en = 1'b0;
        step();
        step();
        check("signed_pulses", 32'(pulses - p0), 32'd2);
        check("signed_acc", 32'(acc), 32'hFFFFE0);
        do_clr();

        // 4. saturation, then a negative word re-clamped from the limit
        a_in = 64'h8080808080808080;
        b_in = 64'h8080808080808080;
        en = 1'b1;
        for (int k = 1; k <= 63; k++) begin
            push(24'(131072 * k), 16'(k), 1'b0);
        end
        push(24'h7FFFFF, 16'd64, 1'b1);
        push(24'h7FFFFF, 16'd65, 1'b1);
        for (int k = 0; k < 65; k++) begin
            step();
        end
        a_in = 64'h0101010101010101;
        b_in = 64'hFFFF_FFFF_FFFF_FFFF;
        push(24'h7FFFF7, 16'd66, 1'b1);
        step();
        en = 1'b0;
        step();
        step();
        check("sat_final_acc", 32'(acc), 32'h7FFFF7);
        check("sat_sticky", 32'(sat), 32'h1);
        check("sat_count", 32'(count), 32'd66);
        do_clr();

        // 5. clr collides with a pending word and a new en
        a_in = 64'h0000000000000064;
        b_in = 64'h0000000000000001;
        en = 1'b1;
        push(24'd100, 16'd1, 1'b0);
        step();
        a_in = 64'h0000000000000007;
        step();
        check("pre_clr_acc", 32'(acc), 32'd100);
        a_in = 64'h0000000000000005;
        b_in = 64'h0000000000000003;
        clr = 1'b1;
        push(24'd15, 16'd1, 1'b0);
        step();
        clr = 1'b0;
        en = 1'b0;
        idle_state("clr_collide");
        step();
        check("collide_acc", 32'(acc), 32'd15);
        check("collide_count", 32'(count), 32'd1);
        step();
        step();

        // 6. reset while a word sits in stage 1
        p0 = pulses;
        a_in = 64'h0102030405060708;
        b_in = 64'h0101010101010101;
        en = 1'b1;
        step();
        en = 1'b0;
        #2;
        rst_n = 1'b0;
        step();
        step();
        idle_state("mid_reset");
        rst_n = 1'b1;
        step();
        step();
        step();
        idle_state("mid_reset_after");
        check("mid_reset_pulses", 32'(pulses - p0), 32'd0);

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
